// File: rtl/fir_stim_source.sv
// Stimulus source for the FIR input stream: emits a pseudo-random signed sample sequence with a valid-gap pattern,
// then drains and raises END_SIM. Define FIR_STIM_RAMP_EN to replace the LFSR with a full-range signed ramp.
module fir_stim_source #(
    parameter int          NB           = 11,
    parameter int          N_SAMPLES    = 64,
    parameter int          GAP_PERIOD   = 4,
    parameter int          DRAIN_CYCLES = 10,
    parameter logic [10:0] SEED         = 11'h5A5
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             START,
    output logic [NB-1:0]                    DOUT,
    output logic                             VOUT,
    output logic                             BUSY,
    output logic                             END_SIM,
    output logic [$clog2(N_SAMPLES+1)-1:0]   SAMPLE_CNT
);
    // VOUT qualifies DOUT for exactly one cycle. There is no ready: the FIR must accept every valid sample.

    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam int GW = (GAP_PERIOD > 0) ? $clog2(GAP_PERIOD + 1) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(N_SAMPLES);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_PERIOD);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt_nx;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_nx;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_cnt_nx;
    logic [NB-1:0] dout_nx;
    logic          vout_nx;
    logic          busy_nx;
    logic          end_nx;
    logic          emit;
    logic [NB-1:0] sample;

`ifdef FIR_STIM_RAMP_EN
    localparam logic [NB-1:0] RAMP_INIT = NB'(1) << (NB - 1);

    logic [NB-1:0] ramp;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ramp <= RAMP_INIT;
        end else if (emit) begin
            ramp <= ramp + NB'(1);
        end
    end

    assign sample = ramp;
`else
    localparam logic [10:0] SEED_EFF = (SEED == 11'd0) ? 11'd1 : SEED;

    logic [10:0] lfsr;

    // x^11 + x^9 + 1, maximal length 2047
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr <= SEED_EFF;
        end else if (emit) begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
        end
    end

    // Signed cast sign-extends for NB > 11 and truncates for NB < 11.
    assign sample = NB'($signed(lfsr));
`endif

    always_comb begin
        state_nx     = state;
        cnt_nx       = SAMPLE_CNT;
        gap_cnt_nx   = gap_cnt;
        drain_cnt_nx = drain_cnt;
        dout_nx      = DOUT;
        vout_nx      = 1'b0;
        emit         = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    emit = 1'b1;
                end
            end
            S_RUN: begin
                // Reaching the sample count wins over a pending gap.
                if (SAMPLE_CNT == CNT_LAST) begin
                    dout_nx      = '0;
                    drain_cnt_nx = '0;
                    state_nx     = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if ((GAP_PERIOD != 0) && (gap_cnt == GAP_LAST)) begin
                    gap_cnt_nx = '0;
                    state_nx   = S_GAP;
                end else begin
                    emit = 1'b1;
                end
            end
            S_GAP: begin
                emit = 1'b1;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    drain_cnt_nx = drain_cnt + DW'(1);
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (emit) begin
            state_nx   = S_RUN;
            vout_nx    = 1'b1;
            dout_nx    = sample;
            cnt_nx     = SAMPLE_CNT + CW'(1);
            gap_cnt_nx = gap_cnt + GW'(1);
        end

        busy_nx = (state_nx == S_RUN) || (state_nx == S_GAP) || (state_nx == S_DRAIN);
        end_nx  = (state_nx == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            SAMPLE_CNT <= '0;
            gap_cnt    <= '0;
            drain_cnt  <= '0;
            DOUT       <= '0;
            VOUT       <= 1'b0;
            BUSY       <= 1'b0;
            END_SIM    <= 1'b0;
        end else begin
            state      <= state_nx;
            SAMPLE_CNT <= cnt_nx;
            gap_cnt    <= gap_cnt_nx;
            drain_cnt  <= drain_cnt_nx;
            DOUT       <= dout_nx;
            VOUT       <= vout_nx;
            BUSY       <= busy_nx;
            END_SIM    <= end_nx;
        end
    end

endmodule
